// File: rtl/ahb_output_arbiter_param.sv
// ahb_output_arbiter_param
// Output-stage arbiter for the AHB bus matrix. Chooses which of NUM_PORTS
// input stages drives the shared slave port, with round-robin or fixed
// priority selection. A granted burst holds the bus until the address phase
// of its last beat. Undefined-length INCR bursts hold for INCR_BEATS beats,
// and stop holding once EARLY_LIMIT held bursts in a row have been cut short.
module ahb_output_arbiter_param #(
  parameter int NUM_PORTS   = 3,
  parameter int ARB_MODE    = 0,
  parameter int INCR_BEATS  = 4,
  parameter int EARLY_LIMIT = 1,
  localparam int PORT_W     = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 hold_active
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [2:0] BURST_WRAP4  = 3'b010;
  localparam logic [2:0] BURST_INCR4  = 3'b011;
  localparam logic [2:0] BURST_WRAP8  = 3'b100;
  localparam logic [2:0] BURST_INCR8  = 3'b101;
  localparam logic [2:0] BURST_WRAP16 = 3'b110;
  localparam logic [2:0] BURST_INCR16 = 3'b111;

  localparam logic [3:0]        INCR_REMAIN = 4'(INCR_BEATS - 2);
  localparam logic [1:0]        EARLY_LIM   = 2'(EARLY_LIMIT);
  localparam logic [PORT_W-1:0] LAST_PORT   = PORT_W'(NUM_PORTS - 1);

  // registered state
  logic [3:0]        remain_q;
  logic              hold_q;
  logic [1:0]        early_q;
  logic [PORT_W-1:0] addr_q;
  logic              no_port_q;

  // combinational next state
  logic [3:0]        remain_nxt;
  logic              hold_nxt;
  logic [1:0]        early_inc;
  logic [1:0]        early_nxt;
  logic [PORT_W-1:0] addr_nxt;
  logic              no_port_nxt;

  // arbitration helpers
  logic              rr_found;
  logic [PORT_W-1:0] rr_idx;
  logic              fp_found;
  logic [PORT_W-1:0] fp_idx;
  logic              cur_req;
  int                idx;

  // Burst length tracking: remaining beats, hold flag and early-termination count.
  // A NONSEQ arriving while a hold is still registered means the previous
  // burst ended early; that count is bumped before the INCR limit test so
  // the offending INCR itself is the one refused a hold.
  always_comb begin
    remain_nxt = remain_q;
    hold_nxt   = hold_q;
    early_inc  = early_q;
    if (hold_q && (HTRANSM == TRANS_NONSEQ) && (early_q != 2'd3))
      early_inc = early_q + 2'd1;

    if (!HSELM) begin
      remain_nxt = 4'd0;
      hold_nxt   = 1'b0;
    end else begin
      case (HTRANSM)
        TRANS_NONSEQ: begin
          case (HBURSTM)
            BURST_WRAP16, BURST_INCR16: begin
              remain_nxt = 4'd14;
              hold_nxt   = 1'b1;
            end
            BURST_WRAP8, BURST_INCR8: begin
              remain_nxt = 4'd6;
              hold_nxt   = 1'b1;
            end
            BURST_WRAP4, BURST_INCR4: begin
              remain_nxt = 4'd2;
              hold_nxt   = 1'b1;
            end
            BURST_INCR: begin
              if (early_inc == EARLY_LIM) begin
                remain_nxt = 4'd0;
                hold_nxt   = 1'b0;
              end else begin
                remain_nxt = INCR_REMAIN;
                hold_nxt   = 1'b1;
              end
            end
            default: begin
              remain_nxt = 4'd0;
              hold_nxt   = 1'b0;
            end
          endcase
        end
        TRANS_SEQ: begin
          if (remain_q == 4'd0)
            hold_nxt = 1'b0;
          else
            remain_nxt = remain_q - 4'd1;
        end
        TRANS_BUSY: begin
          remain_nxt = remain_q;
        end
        default: begin
          remain_nxt = 4'd0;
          hold_nxt   = 1'b0;
        end
      endcase
    end

    early_nxt = hold_nxt ? early_inc : 2'd0;
  end

  // Candidate winners: next rotating requester after the owner, and lowest-index requester.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = addr_q;
    fp_found = 1'b0;
    fp_idx   = addr_q;
    cur_req  = 1'b0;
    idx      = 0;
    for (int k = 1; k < NUM_PORTS; k++) begin
      idx = (int'(addr_q) + k) % NUM_PORTS;
      if (!rr_found && req_port[idx]) begin
        rr_found = 1'b1;
        rr_idx   = PORT_W'(idx);
      end
    end
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_port[i]) begin
        fp_found = 1'b1;
        fp_idx   = PORT_W'(i);
      end
      if (PORT_W'(i) == addr_q)
        cur_req = req_port[i];
    end
  end

  // Grant decision: a lock or burst hold only pins an existing owner.
  always_comb begin
    addr_nxt    = addr_q;
    no_port_nxt = no_port_q;
    if ((HMASTLOCKM || hold_nxt) && !no_port_q) begin
      no_port_nxt = 1'b0;
    end else if (ARB_MODE == 0) begin
      if (rr_found) begin
        addr_nxt    = rr_idx;
        no_port_nxt = 1'b0;
      end else if (!no_port_q && HSELM) begin
        no_port_nxt = 1'b0;
      end else if (no_port_q && cur_req) begin
        no_port_nxt = 1'b0;
      end else begin
        no_port_nxt = 1'b1;
      end
    end else begin
      if (fp_found) begin
        addr_nxt    = fp_idx;
        no_port_nxt = 1'b0;
      end else if (!no_port_q && HSELM) begin
        no_port_nxt = 1'b0;
      end else begin
        no_port_nxt = 1'b1;
      end
    end
  end

  // State update, advancing only on completed transfers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      remain_q  <= 4'd0;
      hold_q    <= 1'b0;
      early_q   <= 2'd0;
      addr_q    <= LAST_PORT;
      no_port_q <= 1'b1;
    end else if (HREADYM) begin
      remain_q  <= remain_nxt;
      hold_q    <= hold_nxt;
      early_q   <= early_nxt;
      addr_q    <= addr_nxt;
      no_port_q <= no_port_nxt;
    end
  end

  assign addr_in_port = addr_q;
  assign no_port      = no_port_q;
  assign hold_active  = hold_q;

endmodule
